// File: rtl/gabor_window_scheduler_pkg.sv
// Shared state encoding, orientation index type and SUM_W -> OUT_W reduction for the Gabor scheduler.
// GABOR_SCHED_SAT_EN selects saturation; otherwise the low OUT_W bits are kept (two's-complement wrap).
package gabor_sched_pkg;

    localparam int NUM_ORIENT_DEF = 4;

    typedef enum logic [2:0] {IDLE, STREAM, ORIENT, FLUSH, DONE} state_t;

    typedef logic [$clog2(NUM_ORIENT_DEF)-1:0] orient_t;

    // Operates on a sign-extended 64-bit value so one function serves any SUM_W/OUT_W pair.
    function automatic logic signed [63:0] reduce_sum(input logic signed [63:0] s, input int out_w);
`ifdef GABOR_SCHED_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
`else
        return (s <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/gabor_window_scheduler_if.sv
// Pixel stream, convolution core and feature-map output signals of the Gabor window scheduler.
// master = scheduler side, slave = surrounding datapath / testbench side.
interface gabor_window_scheduler_if #(
    parameter int IMG_W      = 516,
    parameter int IMG_H      = 516,
    parameter int NUM_ORIENT = 4,
    parameter int SUM_W      = 26,
    parameter int OUT_W      = 16
);
    logic                          pix_valid;
    logic                          pix_ready;
    logic                          win_shift;
    logic [$clog2(NUM_ORIENT)-1:0] coeff_sel;
    logic signed [SUM_W-1:0]       conv_sum;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_W-1:0]       out_data;
    logic [$clog2(NUM_ORIENT)-1:0] out_orient;
    logic [$clog2(IMG_H)-1:0]      out_row;
    logic [$clog2(IMG_W)-1:0]      out_col;

    modport master (
        input  pix_valid, conv_sum, out_ready,
        output pix_ready, win_shift, coeff_sel,
               out_valid, out_data, out_orient, out_row, out_col
    );

    modport slave (
        output pix_valid, conv_sum, out_ready,
        input  pix_ready, win_shift, coeff_sel,
               out_valid, out_data, out_orient, out_row, out_col
    );
endinterface

// File: rtl/gabor_out_reg.sv
// Single-entry valid/ready output register: load lands next cycle; contents hold while valid && !ready.
// free = !valid || ready, so a consume and a new load may share one cycle without losing data.
module gabor_out_reg #(
    parameter int DW = 16,
    parameter int OW = 2,
    parameter int RW = 10,
    parameter int CW = 10
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic signed [DW-1:0] in_data,
    input  logic [OW-1:0]        in_orient,
    input  logic [RW-1:0]        in_row,
    input  logic [CW-1:0]        in_col,
    input  logic                 ready,
    output logic                 valid,
    output logic signed [DW-1:0] out_data,
    output logic [OW-1:0]        out_orient,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 free
);
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            out_data   <= '0;
            out_orient <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else if (load) begin
            valid      <= 1'b1;
            out_data   <= in_data;
            out_orient <= in_orient;
            out_row    <= in_row;
            out_col    <= in_col;
        end else if (ready) begin
            valid      <= 1'b0;
        end
    end
endmodule

// File: rtl/gabor_window_scheduler.sv
// Time-shares one 5x5 Gabor core: 1 accept cycle per pixel plus NUM_ORIENT core cycles per valid window (GABOR_SCHED_SAT_EN: saturate out_data).
// Outputs appear one cycle after coeff_sel presents o; a full output register holds coeff_sel and keeps pix_ready low.
module gabor_window_scheduler
    import gabor_sched_pkg::*;
#(
    parameter int IMG_W       = 516,
    parameter int IMG_H       = 516,
    parameter int KERNEL_SIZE = 5,
    parameter int NUM_ORIENT  = 4,
    parameter int SUM_W       = 26,
    parameter int OUT_W       = 16
)(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    gabor_window_scheduler_if.master bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int OW = $clog2(NUM_ORIENT);

    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_OFF   = RW'((KERNEL_SIZE - 1) / 2);
    localparam logic [CW-1:0] COL_OFF   = CW'((KERNEL_SIZE - 1) / 2);
    localparam logic [OW-1:0] O_LAST    = OW'(NUM_ORIENT - 1);

    state_t                  state;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [RW-1:0]           win_row;
    logic [CW-1:0]           win_col;
    logic [OW-1:0]           orient;
    logic                    last_win;
    logic                    accept;
    logic                    win_done;
    logic                    is_last;
    logic                    free;
    logic                    load;
    logic signed [SUM_W-1:0] sum;

    assign bus.pix_ready = (state == STREAM);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign bus.win_shift = accept;
    assign bus.coeff_sel = orient;
    assign busy          = (state == STREAM) || (state == ORIENT) || (state == FLUSH);
    assign done          = (state == DONE);
    assign win_done      = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign is_last       = (row == ROW_LAST) && (col == COL_LAST);
    assign load          = (state == ORIENT) && free;
    assign sum           = bus.conv_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            win_row  <= '0;
            win_col  <= '0;
            orient   <= '0;
            last_win <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= STREAM;
                    row   <= '0;
                    col   <= '0;
                end
                STREAM: if (accept) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    // Coordinates are those of the pixel that completed the window, recentred.
                    if (win_done) begin
                        state    <= ORIENT;
                        orient   <= '0;
                        win_row  <= row - ROW_OFF;
                        win_col  <= col - COL_OFF;
                        last_win <= is_last;
                    end else if (is_last) begin
                        state <= FLUSH;
                    end
                end
                ORIENT: if (free) begin
                    if (orient == O_LAST) begin
                        orient <= '0;
                        state  <= last_win ? FLUSH : STREAM;
                    end else begin
                        orient <= orient + 1'b1;
                    end
                end
                FLUSH: if (!bus.out_valid) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    gabor_out_reg #(.DW(OUT_W), .OW(OW), .RW(RW), .CW(CW)) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .in_data    (OUT_W'(reduce_sum(64'(sum), OUT_W))),
        .in_orient  (orient),
        .in_row     (win_row),
        .in_col     (win_col),
        .ready      (bus.out_ready),
        .valid      (bus.out_valid),
        .out_data   (bus.out_data),
        .out_orient (bus.out_orient),
        .out_row    (bus.out_row),
        .out_col    (bus.out_col),
        .free       (free)
    );
endmodule

// File: tb/tb_gabor_window_scheduler.sv
// Bench for gabor_window_scheduler on an 8x6 image; conv_sum is a function of coeff_sel and the last accepted pixel.
// Expected output streams come from a nested-loop model over windows and orientations.
module tb_gabor_window_scheduler;
    localparam int IMG_W = 8, IMG_H = 6, K = 5, NO = 4, SUM_W = 26, OUT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    gabor_window_scheduler_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_ORIENT(NO),
                                .SUM_W(SUM_W), .OUT_W(OUT_W)) bus ();

    gabor_window_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL_SIZE(K),
                             .NUM_ORIENT(NO), .SUM_W(SUM_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests, fails;
    int sum_mode, sum_off, row_w, cur_row, cur_col;
    logic signed [SUM_W-1:0] sum_const;

    assign bus.conv_sum = (sum_mode != 0) ? sum_const
                        : SUM_W'(100 * int'(bus.coeff_sel) + row_w * cur_row + cur_col + sum_off);

    int obs_d[$], obs_o[$], obs_r[$], obs_c[$];
    int exp_d[$], exp_o[$], exp_r[$], exp_c[$];
    int acc, done_cnt, busy_cnt, stall_err, orient_err, shift_err, busydone_err, first_ov, acc_neg;
    bit timed_out;

    function automatic int ref_reduce(input int v);
`ifdef GABOR_SCHED_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int m;
        m = v % 65536;
        if (m < 0) m += 65536;
        if (m >= 32768) m -= 65536;
        return m;
`endif
    endfunction

    function automatic void build_exp();
        exp_d.delete(); exp_o.delete(); exp_r.delete(); exp_c.delete();
        for (int r = K - 1; r < IMG_H; r++)
            for (int c = K - 1; c < IMG_W; c++)
                for (int o = 0; o < NO; o++) begin
                    exp_d.push_back(ref_reduce((sum_mode != 0) ? int'(sum_const)
                                               : 100 * o + row_w * r + c + sum_off));
                    exp_o.push_back(o);
                    exp_r.push_back(r - (K - 1) / 2);
                    exp_c.push_back(c - (K - 1) / 2);
                end
    endfunction

    function automatic int first_bad();
        if (obs_d.size() != exp_d.size()) return -2;
        foreach (exp_d[i])
            if (obs_d[i] != exp_d[i] || obs_o[i] != exp_o[i] ||
                obs_r[i] != exp_r[i] || obs_c[i] != exp_c[i]) return i;
        return -1;
    endfunction

    // Runs one frame from a start pulse; mode 0 = always high, 1 = periodic, 2 = random.
    task automatic run_frame(input int rdy_mode, input int vld_mode, input int extra_start,
                             input bit abort_o2, output bit aborted);
        int consumed, win_cnt, post, r, c, hd, ho, hr, hc;
        bit pend, held;
        obs_d.delete(); obs_o.delete(); obs_r.delete(); obs_c.delete();
        acc = 0; done_cnt = 0; busy_cnt = 0; stall_err = 0; orient_err = 0; shift_err = 0;
        busydone_err = 0; first_ov = -1; acc_neg = -1; timed_out = 1; aborted = 0;
        consumed = 0; win_cnt = 0; post = -1; pend = 0; held = 0;
        r = 0; c = 0; hd = 0; ho = 0; hr = 0; hc = 0;
        cur_row = 0; cur_col = 0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (done && busy) busydone_err++;
            if (bus.win_shift !== (bus.pix_valid && bus.pix_ready)) shift_err++;
            if (bus.pix_ready && (consumed + int'(bus.out_valid)) < NO * win_cnt) orient_err++;
            if (held && (bus.out_valid !== 1'b1 || int'(bus.out_data) != hd ||
                         int'(bus.out_orient) != ho || int'(bus.out_row) != hr ||
                         int'(bus.out_col) != hc)) stall_err++;
            held = bus.out_valid && !bus.out_ready;
            hd = int'(bus.out_data); ho = int'(bus.out_orient);
            hr = int'(bus.out_row);  hc = int'(bus.out_col);
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (bus.out_valid && bus.out_ready) begin
                obs_d.push_back(hd); obs_o.push_back(ho); obs_r.push_back(hr); obs_c.push_back(hc);
                consumed++;
            end
            pend = bus.win_shift;
            if (pend) begin
                r = acc / IMG_W;
                c = acc % IMG_W;
                if (acc == (K - 1) * IMG_W + (K - 1)) acc_neg = cyc;
            end
            if (abort_o2 && busy && bus.coeff_sel == 2) begin
                rst_n = 1'b0;
                aborted = 1;
                timed_out = 0;
                return;
            end
            if (done && post < 0) post = 4;
            if (post == 0) begin
                timed_out = 0;
                break;
            end
            if (post > 0) post--;
            @(posedge clk); #1;
            if (pend) begin
                acc++;
                cur_row = r;
                cur_col = c;
                if (r >= K - 1 && c >= K - 1) win_cnt++;
            end
            start = (cyc == extra_start);
            bus.pix_valid = (vld_mode == 0) ? 1'b1 : (vld_mode == 1) ? (cyc % 2 == 1)
                          : 1'($urandom_range(0, 1));
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 2)
                          : 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.pix_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        tests++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL reset_pix_ready: got %b expected 0", bus.pix_ready); end
        tests++; if (bus.win_shift !== 1'b0) begin fails++; $display("FAIL reset_win_shift: got %b expected 0", bus.win_shift); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.coeff_sel !== '0) begin fails++; $display("FAIL reset_coeff_sel: got %0d expected 0", bus.coeff_sel); end
        tests++; if ({bus.out_data, bus.out_orient, bus.out_row, bus.out_col} !== '0) begin
            fails++; $display("FAIL reset_out_fields: got %h expected 0", {bus.out_data, bus.out_orient, bus.out_row, bus.out_col}); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({busy, bus.pix_ready} !== 2'b00) begin fails++; $display("FAIL idle_after_reset: got %b expected 00", {busy, bus.pix_ready}); end
    endtask

    task automatic test_full_rate();
        bit ab;
        int bad;
        sum_mode = 0; sum_off = 0; row_w = 0;
        run_frame(0, 0, -1, 0, ab);
        build_exp();
        tests++; if (timed_out) begin fails++; $display("FAIL full_timeout: got no done expected done"); end
        tests++; if (obs_d.size() != 32) begin fails++; $display("FAIL full_count: got %0d expected 32", obs_d.size()); end
        if (obs_d.size() >= 4) begin
            tests++; if (obs_d[0] != 4 || obs_d[1] != 104 || obs_d[2] != 204 || obs_d[3] != 304) begin
                fails++; $display("FAIL full_first_data: got %0d %0d %0d %0d expected 4 104 204 304", obs_d[0], obs_d[1], obs_d[2], obs_d[3]); end
            tests++; if (obs_r[0] != 2 || obs_c[0] != 2) begin
                fails++; $display("FAIL full_first_coord: got (%0d,%0d) expected (2,2)", obs_r[0], obs_c[0]); end
        end
        bad = first_bad();
        tests++; if (bad != -1) begin fails++; $display("FAIL full_stream: got bad index %0d expected -1", bad); end
        tests++; if (first_ov - acc_neg != 2) begin fails++; $display("FAIL full_latency: got %0d expected 2", first_ov - acc_neg); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
        tests++; if (busy_cnt != 82) begin fails++; $display("FAIL full_busy_cycles: got %0d expected 82", busy_cnt); end
        tests++; if (acc != 48) begin fails++; $display("FAIL full_accepts: got %0d expected 48", acc); end
        tests++; if (busydone_err != 0) begin fails++; $display("FAIL full_busy_with_done: got %0d expected 0", busydone_err); end
    endtask

    task automatic test_backpressure();
        bit ab;
        int bad;
        sum_mode = 0; sum_off = $urandom_range(0, 1000); row_w = $urandom_range(0, 500);
        run_frame(1, 0, -1, 0, ab);
        build_exp();
        bad = first_bad();
        tests++; if (bad != -1) begin fails++; $display("FAIL bp_stream: got bad index %0d expected -1", bad); end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stable: got %0d changes expected 0", stall_err); end
        tests++; if (orient_err != 0) begin fails++; $display("FAIL bp_pix_ready_orient: got %0d expected 0", orient_err); end
        tests++; if (done_cnt != 1 || timed_out) begin fails++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_saturation();
        bit ab;
        int bad, expv;
        sum_mode = 1;
        for (int k = 0; k < 2; k++) begin
            sum_const = (k == 0) ? 26'sd40000 : -26'sd40000;
`ifdef GABOR_SCHED_SAT_EN
            expv = (k == 0) ? 32767 : -32768;
`else
            expv = (k == 0) ? -25536 : 25536;
`endif
            run_frame(2, 0, -1, 0, ab);
            bad = 0;
            foreach (obs_d[i]) if (obs_d[i] != expv) bad++;
            tests++; if (obs_d.size() != 32 || bad != 0) begin
                fails++; $display("FAIL sat_%0d: got %0d outputs %0d wrong (first %0d) expected 32 of %0d",
                                  k, obs_d.size(), bad, (obs_d.size() > 0) ? obs_d[0] : 0, expv); end
        end
        sum_mode = 0;
    endtask

    task automatic test_gapped();
        bit ab;
        int bad;
        sum_mode = 0; sum_off = $urandom_range(0, 1000); row_w = $urandom_range(0, 500);
        run_frame(0, 1, -1, 0, ab);
        build_exp();
        bad = first_bad();
        tests++; if (acc != 48) begin fails++; $display("FAIL gap_accepts: got %0d expected 48", acc); end
        tests++; if (shift_err != 0) begin fails++; $display("FAIL gap_win_shift: got %0d expected 0", shift_err); end
        tests++; if (bad != -1) begin fails++; $display("FAIL gap_stream: got bad index %0d expected -1", bad); end
        tests++; if (orient_err != 0) begin fails++; $display("FAIL gap_pix_ready_orient: got %0d expected 0", orient_err); end
    endtask

    task automatic test_abort();
        bit ab;
        int bad;
        sum_mode = 0; sum_off = $urandom_range(0, 1000); row_w = $urandom_range(0, 500);
        run_frame(0, 0, -1, 1, ab);
        #1;
        tests++; if (!ab) begin fails++; $display("FAIL abort_reached: got 0 expected 1"); end
        tests++; if ({busy, done, bus.pix_ready, bus.win_shift, bus.out_valid} !== 5'b0) begin
            fails++; $display("FAIL abort_ctrl: got %b expected 00000", {busy, done, bus.pix_ready, bus.win_shift, bus.out_valid}); end
        tests++; if ({bus.coeff_sel, bus.out_data, bus.out_orient, bus.out_row, bus.out_col} !== '0) begin
            fails++; $display("FAIL abort_fields: got %h expected 0", {bus.coeff_sel, bus.out_data, bus.out_orient, bus.out_row, bus.out_col}); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sum_off = $urandom_range(0, 1000);
        run_frame(0, 0, -1, 0, ab);
        build_exp();
        bad = first_bad();
        tests++; if (bad != -1 || acc != 48) begin fails++; $display("FAIL abort_restart: got bad index %0d accepts %0d expected -1 and 48", bad, acc); end
    endtask

    task automatic test_start_busy();
        bit ab;
        int bad;
        sum_mode = 0; sum_off = $urandom_range(0, 1000); row_w = $urandom_range(0, 500);
        run_frame(0, 0, 20, 0, ab);
        build_exp();
        bad = first_bad();
        tests++; if (obs_d.size() != 32) begin fails++; $display("FAIL sb_count: got %0d expected 32", obs_d.size()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL sb_done: got %0d expected 1", done_cnt); end
        tests++; if (bad != -1) begin fails++; $display("FAIL sb_stream: got bad index %0d expected -1", bad); end
    endtask

    task automatic test_random();
        bit ab;
        int bad;
        for (int k = 0; k < 3; k++) begin
            sum_mode = 0; sum_off = $urandom_range(0, 1000); row_w = $urandom_range(0, 500);
            run_frame(2, 2, -1, 0, ab);
            build_exp();
            bad = first_bad();
            tests++; if (bad != -1 || timed_out) begin fails++; $display("FAIL rand_stream_%0d: got bad index %0d expected -1", k, bad); end
            tests++; if (stall_err != 0 || orient_err != 0 || shift_err != 0) begin
                fails++; $display("FAIL rand_protocol_%0d: got %0d/%0d/%0d expected 0/0/0", k, stall_err, orient_err, shift_err); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        bus.pix_valid = 1'b0; bus.out_ready = 1'b0;
        sum_mode = 0; sum_off = 0; row_w = 0; sum_const = '0; cur_row = 0; cur_col = 0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_saturation();
        test_gapped();
        test_abort();
        test_start_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
